// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the decoder scan driver (GUARD state only with SCAN_GUARD_EN)
package scan_pkg;

`ifdef SCAN_GUARD_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_GUARD = 2'd2} scan_state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1} scan_state_e;
`endif

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Enable vectors ordered {e3, e2, e1}
  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

  function automatic logic [2:0] addr_step(input logic [2:0] a, input logic d);
    return (d == DIR_DOWN) ? a - 3'd1 : a + 3'd1;
  endfunction

  function automatic logic addr_wraps(input logic [2:0] a, input logic d);
    return (d == DIR_DOWN) ? (a == 3'd0) : (a == 3'd7);
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot prescaler with clear, enable and terminal-count pulse
module scan_prescaler #(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign tc_o = en_i && !clr_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan_driver.sv
// rtl/decoder_scan_driver.sv - 3-to-8 decoder scan FSM and address counter; SCAN_GUARD_EN adds a blanking GUARD clock per address change
module decoder_scan_driver
  import scan_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       dir,
  input  logic       blank,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       step,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       tick,
  output logic       wrap
);

  scan_state_e state_q, state_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  en_q, en_d;
  logic        wrap_q, wrap_d;
  logic        adv;
  logic        pre_en;
  logic        tc;

  // The GUARD clock counts as the first clock of the next slot, so slot length is unchanged
  assign pre_en = run && (state_q != ST_IDLE);

  scan_prescaler #(
    .DIV_WIDTH(DIV_WIDTH),
    .DIV_MAX  (DIV_MAX)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr_i(!pre_en),
    .en_i (pre_en),
    .tc_o (tc)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;
    adv     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        adv = step;
        if (run) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (tc) begin
`ifdef SCAN_GUARD_EN
          state_d = ST_GUARD;
`else
          adv = 1'b1;
`endif
        end
      end
`ifdef SCAN_GUARD_EN
      ST_GUARD: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN;
          adv     = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      addr_d = load_val;
    end else if (adv) begin
      addr_d = addr_step(addr_q, dir);
      wrap_d = addr_wraps(addr_q, dir);
    end

    en_d = (state_d == ST_SCAN && !blank) ? EN_ON : EN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 3'd0;
      en_q    <= EN_OFF;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign {a2, a1, a0} = addr_q;
  assign {e3, e2, e1} = en_q;
  assign tick         = tc;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// tb/tb_decoder_scan_driver.sv - randomized self-checking bench with a slot-level reference model (honours SCAN_GUARD_EN)
module tb_decoder_scan_driver;

  localparam int DIV_MAX = 3;
`ifdef SCAN_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, run, dir, blank, load, step;
  logic [2:0] load_val;
  logic a0, a1, a2, e1, e2, e3, tick, wrap;

  int total = 0;
  int bad   = 0;

  decoder_scan_driver #(.DIV_WIDTH(4), .DIV_MAX(DIV_MAX)) dut (
    .clk(clk), .rst(rst), .run(run), .dir(dir), .blank(blank), .load(load),
    .load_val(load_val), .step(step), .a0(a0), .a1(a1), .a2(a2),
    .e1(e1), .e2(e2), .e3(e3), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 scanning, 2 guard clock; phase = clocks into the current slot
  int m_mode, m_phase, m_addr, m_next;
  bit m_wrap, m_en, m_adv, m_tk;

  initial begin
    m_mode = 0; m_phase = 0; m_addr = 0; m_wrap = 0; m_en = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_phase = 0; m_addr = 0; m_wrap = 0; m_en = 0;
      end else begin
        m_tk   = (m_mode != 0) && run && (m_phase == DIV_MAX);
        m_adv  = 0;
        m_next = m_mode;
        if (m_mode == 0) begin
          m_adv   = step;
          m_phase = 0;
          if (run) m_next = 1;
        end else if (!run) begin
          m_next  = 0;
          m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % (DIV_MAX + 1);
          if (m_mode == 2) begin
            m_next = 1;
            m_adv  = 1;
          end else if (m_tk) begin
            if (GUARD) m_next = 2;
            else m_adv = 1;
          end
        end
        m_wrap = 0;
        if (load) begin
          m_addr = int'(load_val);
        end else if (m_adv) begin
          m_wrap = dir ? (m_addr == 0) : (m_addr == 7);
          m_addr = (m_addr + (dir ? 7 : 1)) % 8;
        end
        m_mode = m_next;
        m_en   = (m_mode == 1) && !blank;
      end
      #2;
      check("model_addr", {29'd0, a2, a1, a0}, m_addr);
      check("model_en", {29'd0, e3, e2, e1}, m_en ? 3'b100 : 3'b011);
      check("model_tick", tick, (m_mode != 0) && run && (m_phase == DIV_MAX));
      check("model_wrap", wrap, m_wrap);
    end
  end

  task automatic wait_tick();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if (tick) return;
    end
    total++; bad++;
    $display("FAIL tick_timeout: got no tick expected tick within 20 clocks");
  endtask

  int ticks, wraps, offs, guard_offs;

  initial begin
    rst = 1; run = 0; dir = 0; blank = 0; load = 0; load_val = 0; step = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_addr", {a2, a1, a0}, 3'd0);
    check("rst_en", {e3, e2, e1}, 3'b011);
    check("rst_tick", tick, 0);
    check("rst_wrap", wrap, 0);
    @(negedge clk) rst = 0;

    // Continuous up scan: 40 clocks hold 10 ticks, 9 advances and one 7->0 wrap
    @(negedge clk) begin run = 1; dir = 0; end
    @(posedge clk); #2;
    check("scan_start_en", {e3, e2, e1}, 3'b100);
    check("scan_start_addr", {a2, a1, a0}, 3'd0);
    ticks = 0; wraps = 0; offs = 0;
    for (int i = 0; i < 40; i++) begin
      if (i != 0) begin @(posedge clk); #2; end
      ticks += int'(tick);
      wraps += int'(wrap);
      offs  += int'(!e3);
    end
    guard_offs = GUARD ? 9 : 0;
    check("up_ticks", ticks, 10);
    check("up_wraps", wraps, 1);
    check("up_addr", {a2, a1, a0}, 3'd1);
    check("up_off_clocks", offs, guard_offs);

    // Load coinciding with terminal count wins over the advance
    wait_tick();
    #1 begin load = 1; load_val = 6; end
    @(posedge clk); #2;
    check("load_tc_addr", {a2, a1, a0}, 3'd6);
    check("load_tc_wrap", wrap, 0);
    @(negedge clk) load = 0;

    // Blanking
    @(negedge clk) blank = 1;
    @(posedge clk); #2;
    check("blank_e3", e3, 0);
    repeat (9) @(posedge clk);
    @(negedge clk) blank = 0;
    @(posedge clk); #2;
    if (!GUARD) check("unblank_e3", e3, 1);

    // Stop mid-slot at address 3, then step in IDLE
    @(negedge clk) run = 0;
    @(negedge clk) begin load = 1; load_val = 3; end
    @(negedge clk) begin load = 0; run = 1; dir = 0; end
    wait_tick();
`ifdef SCAN_GUARD_EN
    @(posedge clk); #2;
    check("guard_e3", e3, 0);
`endif
    #1 run = 0;
    @(posedge clk); #2;
    check("stop_addr", {a2, a1, a0}, 3'd3);
    check("stop_e3", e3, 0);
    @(negedge clk) step = 1;
    @(posedge clk); #2;
    check("step_addr", {a2, a1, a0}, 3'd4);
    check("step_en", {e3, e2, e1}, 3'b011);
    @(negedge clk) step = 0;

    // Down scan from 0 wraps to 7
    @(negedge clk) begin load = 1; load_val = 0; dir = 1; end
    @(negedge clk) begin load = 0; run = 1; end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      if ({a2, a1, a0} != 3'd0) break;
    end
    check("down_addr", {a2, a1, a0}, 3'd7);
    check("down_wrap", wrap, 1);
    if (!GUARD) check("down_e3", e3, 1);

    // Asynchronous reset while scanning at address 5
    @(negedge clk) begin load = 1; load_val = 5; end
    @(negedge clk) load = 0;
    check("pre_rst_addr", {a2, a1, a0}, 3'd5);
    #1 rst = 1;
    #1;
    check("async_rst_addr", {a2, a1, a0}, 3'd0);
    check("async_rst_en", {e3, e2, e1}, 3'b011);
    check("async_rst_tick", tick, 0);
    @(negedge clk) rst = 0;

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      run      = ($urandom_range(0, 29) == 0) ? ~run : run;
      dir      = ($urandom_range(0, 15) == 0) ? ~dir : dir;
      blank    = ($urandom_range(0, 9) == 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = 3'($urandom);
      step     = ($urandom_range(0, 3) == 0);
    end

    @(negedge clk) begin rst = 0; run = 0; load = 0; step = 0; blank = 0; end
    @(posedge clk); #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
